// File: rtl/pacing_scheduler_if.sv
// pacing_scheduler_if: event input, task handshake and queue debug signals of the pacing scheduler
interface pacing_scheduler_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int TS_WIDTH    = 64,
    parameter int QUEUE_DEPTH = 4
);
    localparam int LW = $clog2(QUEUE_DEPTH) + 1;
    logic                         en;
    logic signed [DATA_WIDTH-1:0] input_0;
    logic                         new_input_0;
    logic signed [DATA_WIDTH-1:0] task_data;
    logic [TS_WIDTH-1:0]          task_ts;
    logic                         task_event;
    logic                         task_periodic;
    logic                         task_valid;
    logic                         task_ready;
    logic                         q_push;
    logic                         q_pop;
    logic                         q_push_valid;
    logic                         q_pop_valid;
    logic [LW-1:0]                level;
    logic                         overflow;
    modport master (
        input  en, input_0, new_input_0, task_ready,
        output task_data, task_ts, task_event, task_periodic, task_valid,
               q_push, q_pop, q_push_valid, q_pop_valid, level, overflow
    );
    modport slave (
        output en, input_0, new_input_0, task_ready,
        input  task_data, task_ts, task_event, task_periodic, task_valid,
               q_push, q_pop, q_push_valid, q_pop_valid, level, overflow
    );
endinterface

// File: rtl/pacing_scheduler.sv
// pacing_scheduler: merges event arrivals and periodic ticks into one time-ordered task FIFO
module pacing_scheduler #(
    parameter int DATA_WIDTH    = 64,
    parameter int TS_WIDTH      = 64,
    parameter int PERIOD_CYCLES = 500,
    parameter int QUEUE_DEPTH   = 4
) (
    input logic               clk,
    input logic               rst,
    pacing_scheduler_if.master io_bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PERIOD_CYCLES);

    logic [DATA_WIDTH-1:0] r_mem_data [QUEUE_DEPTH];
    logic [TS_WIDTH-1:0]   r_mem_ts   [QUEUE_DEPTH];
    logic                  r_mem_ev   [QUEUE_DEPTH];
    logic                  r_mem_per  [QUEUE_DEPTH];
    logic [TS_WIDTH-1:0]   r_ts;
    logic [PW-1:0]         r_cnt;
    logic [LW-1:0]         r_wr;
    logic [LW-1:0]         r_rd;
    logic [DATA_WIDTH-1:0] r_held;
    logic [DATA_WIDTH-1:0] r_last_data;
    logic [TS_WIDTH-1:0]   r_last_ts;
    logic                  r_overflow;

    logic                  w_tick;
    logic [LW-1:0]         w_level;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [DATA_WIDTH-1:0] w_data;
    logic [AW-1:0]         w_rd_idx;
    logic [AW-1:0]         w_wr_idx;

    // Queue status and handshake decisions; debug strobes are forced low during reset.
    always_comb begin
        w_tick    = io_bus.en & (r_cnt == PW'(PERIOD_CYCLES - 1));
        w_level   = r_wr - r_rd;
        w_valid   = w_level != '0;
        w_full    = w_level == LW'(QUEUE_DEPTH);
        w_push    = ~rst & io_bus.en & (io_bus.new_input_0 | w_tick);
        w_pop     = ~rst & io_bus.en & io_bus.task_ready;
        w_pop_ok  = w_pop & w_valid;
        w_push_ok = w_push & (~w_full | w_pop_ok);
        w_data    = io_bus.new_input_0 ? io_bus.input_0 : r_held;
        w_rd_idx  = r_rd[AW-1:0];
        w_wr_idx  = r_wr[AW-1:0];
    end

    assign io_bus.task_valid    = w_valid;
    assign io_bus.task_data     = w_valid ? r_mem_data[w_rd_idx] : r_last_data;
    assign io_bus.task_ts       = w_valid ? r_mem_ts[w_rd_idx] : r_last_ts;
    assign io_bus.task_event    = w_valid & r_mem_ev[w_rd_idx];
    assign io_bus.task_periodic = w_valid & r_mem_per[w_rd_idx];
    assign io_bus.q_push        = w_push;
    assign io_bus.q_pop         = w_pop;
    assign io_bus.q_push_valid  = w_push_ok;
    assign io_bus.q_pop_valid   = w_pop_ok;
    assign io_bus.level         = w_level;
    assign io_bus.overflow      = r_overflow;

    // Entry storage; a merged event+tick writes a single entry carrying both flags.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_data[w_wr_idx] <= w_data;
            r_mem_ts[w_wr_idx]   <= r_ts;
            r_mem_ev[w_wr_idx]   <= io_bus.new_input_0;
            r_mem_per[w_wr_idx]  <= w_tick;
        end
    end

    // Timebase, period phase, pointers and sticky overflow; the last popped head is kept for display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts        <= '0;
            r_cnt       <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_held      <= '0;
            r_last_data <= '0;
            r_last_ts   <= '0;
            r_overflow  <= 1'b0;
        end else if (io_bus.en) begin
            r_ts  <= r_ts + TS_WIDTH'(1);
            r_cnt <= w_tick ? '0 : r_cnt + PW'(1);
            if (io_bus.new_input_0) r_held <= io_bus.input_0;
            if (w_push_ok) r_wr <= r_wr + LW'(1);
            if (w_push & ~w_push_ok) r_overflow <= 1'b1;
            if (w_pop_ok) begin
                r_rd        <= r_rd + LW'(1);
                r_last_data <= r_mem_data[w_rd_idx];
                r_last_ts   <= r_mem_ts[w_rd_idx];
            end
        end
    end
endmodule

// File: doc/pacing_scheduler.md
Name: pacing_scheduler

Overview:
- Sequences evaluation steps for the generated stream monitor. Merges event-based input arrivals and a periodic deadline tick into one time-ordered task queue.
- Each queued task carries a timestamp, the input value and pacing flags.
- Tasks are released to the evaluation datapath over a valid/ready handshake.
- Drives the q_push/q_pop/q_push_valid/q_pop_valid debug signals the monitor exposes.

Parameters:
- DATA_WIDTH, 64, width of the signed input value.
- TS_WIDTH, 64, width of the cycle timestamp counter.
- PERIOD_CYCLES, 500, enabled cycles between periodic ticks (1 ms at 2 us clock); must be >= 2.
- QUEUE_DEPTH, 4, task queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  clock enable; when low the whole block holds state
- input_0  in  DATA_WIDTH  signed input value, sampled when new_input_0=1
- new_input_0  in  1  one-cycle event strobe
- task_data  out  DATA_WIDTH  head entry value
- task_ts  out  TS_WIDTH  head entry timestamp
- task_event  out  1  head entry: event pacing (pacing_in0) due
- task_periodic  out  1  head entry: periodic pacing due
- task_valid  out  1  queue non-empty
- task_ready  in  1  evaluator accepts head this cycle
- q_push  out  1  push attempted this cycle
- q_pop  out  1  pop attempted this cycle
- q_push_valid  out  1  push accepted this cycle
- q_pop_valid  out  1  pop performed this cycle
- level  out  clog2(QUEUE_DEPTH)+1  current queue occupancy
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (async, rst=1): ts=0, period counter=0, queue empty, held value=0, overflow=0. All outputs are 0 while reset is asserted, including task_* fields.
- All state updates happen only on a posedge with en=1. With en=0, strobes are ignored and q_* are 0.
- ts increments by 1 every enabled cycle and wraps modulo 2^TS_WIDTH. A task's timestamp is the ts value in its push cycle.
- Period counter runs 0..PERIOD_CYCLES-1 and wraps. tick=1 in the enabled cycle where the counter equals PERIOD_CYCLES-1, so the first tick falls on the PERIOD_CYCLES-th enabled cycle after reset.
- Push request q_push = en & (new_input_0 | tick).
- Entry contents:
  - event flag = new_input_0; periodic flag = tick.
  - If new_input_0=1, data = input_0 and the held value is updated to input_0.
  - Periodic-only entries carry the held value (last event value).
  - A simultaneous event and tick produce ONE merged entry with both flags set; never two entries.
- Pop request q_pop = en & task_ready. A pop is performed (q_pop_valid=1) only if task_valid=1.
- Push acceptance q_push_valid = q_push & (not full, or pop performed in the same cycle). Push and pop in the same cycle when full are both performed; level is unchanged.
- Dropped push: q_push=1, q_push_valid=0, overflow set to 1 and held until reset; the held value is still updated.
- Latency:
  - Entry pushed at edge N is visible at the head at N+1 if the queue was empty.
  - task_* outputs come straight from head storage registers; there is no combinational path from new_input_0 or input_0.
- Ordering: strict FIFO. Timestamps are non-decreasing except across ts wrap.
- task_valid=0 implies task_event=task_periodic=0; task_data and task_ts hold their last value.
- Queue pointers use an extra wrap bit: full = (level == QUEUE_DEPTH), empty = (level == 0).
- Reset mid-operation discards all queued tasks immediately (async) and restarts the period phase.

Test Plan:
- Reset, PERIOD_CYCLES=8, task_ready=1, no events. Expect:
  - All outputs 0 during rst.
  - Periodic tasks with ts=7, 15, 23, each with task_periodic=1, task_event=0, task_data=0.
  - q_pop_valid one cycle after each push.
- Event input_0=5 at ts=3, PERIOD_CYCLES=8. Expect:
  - Task {ts=3, data=5, event=1, periodic=0} at cycle 4.
  - Next periodic task {ts=7, data=5, event=0, periodic=1}.
- Event input_0=9 on the tick cycle ts=7. Expect exactly one task {ts=7, data=9, event=1, periodic=1}; level never exceeds 1.
- task_ready=0, QUEUE_DEPTH=4, five events 1..5 on consecutive cycles. Expect:
  - level=4.
  - Fifth event: q_push=1, q_push_valid=0, overflow=1.
  - With task_ready=1, tasks pop in order data 1, 2, 3, 4; overflow stays 1.
- Queue full with task_ready=1 and an event in the same cycle. Expect q_push_valid=1, q_pop_valid=1, level stays 4, overflow stays 0.
- en=0 for 10 cycles with events strobed; then rst pulsed while level=3. Expect:
  - During en=0: ts frozen, no pushes.
  - On rst: level=0 and task_valid=0 asynchronously; next periodic tick at ts=7 after release.
